// File: rtl/csr_reg_bank.sv
// CSR bank behind the generic bus request port: CTRL (RW), STATUS (W1C + hw set), ID (RO), scratch (RW).
// Request sampled at edge N gives a one-cycle bus_ready in cycle N+1; a held request is ignored until it drops.
module csr_reg_bank #(
    parameter int                    ADDR_WIDTH = 3,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 8,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hC5A0_0001
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    o_bus_req,
    input  logic                    o_bus_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   o_bus_addr,
    input  logic [DATA_WIDTH-1:0]   o_bus_wr_data,
    input  logic [DATA_WIDTH/8-1:0] o_bus_wr_biten,
    output logic                    bus_ready,
    output logic [DATA_WIDTH-1:0]   bus_rd_data,
    output logic                    bus_err,
    input  logic [DATA_WIDTH-1:0]   hw_set,
    output logic [DATA_WIDTH-1:0]   ctrl_o,
    output logic                    irq_o
);
    localparam int NB         = DATA_WIDTH / 8;
    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;
    localparam int ID_IDX     = 2;
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);

    typedef enum logic [1:0] {IDLE, RESP, WAIT_DROP} state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [DATA_WIDTH-1:0]   w1c_mask;
    logic [DATA_WIDTH-1:0]   rd_val;
    logic                    access_err;
    logic                    commit;
    logic                    wr_ok;

    always_comb begin
        byte_mask = '0;
        for (int b = 0; b < NB; b++) begin
            byte_mask[8*b +: 8] = {8{o_bus_wr_biten[b]}};
        end
        access_err = ({1'b0, o_bus_addr} >= NUM_REGS_W) ||
                     (o_bus_req_is_wr && (o_bus_addr == ADDR_WIDTH'(ID_IDX)));
        commit = (state_q == IDLE) && o_bus_req;
        wr_ok  = commit && o_bus_req_is_wr && !access_err;

        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (o_bus_addr == ADDR_WIDTH'(i)) begin
                rd_val = (i == ID_IDX) ? ID_VALUE : regs_q[i];
            end
        end

        w1c_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (o_bus_addr == ADDR_WIDTH'(i))) begin
                if (i == STATUS_IDX) begin
                    w1c_mask = o_bus_wr_data & byte_mask;
                end else begin
                    regs_d[i] = (regs_q[i] & ~byte_mask) | (o_bus_wr_data & byte_mask);
                end
            end
        end
        // hw_set is applied after the clear so a coincident set wins.
        regs_d[STATUS_IDX] = (regs_q[STATUS_IDX] & ~w1c_mask) | hw_set;
        regs_d[ID_IDX]     = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_ready   <= 1'b0;
            bus_rd_data <= '0;
            bus_err     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            case (state_q)
                IDLE: begin
                    if (commit) begin
                        state_q     <= RESP;
                        bus_ready   <= 1'b1;
                        bus_err     <= access_err;
                        bus_rd_data <= (!o_bus_req_is_wr && !access_err) ? rd_val : '0;
                    end
                end
                RESP: begin
                    bus_ready   <= 1'b0;
                    bus_rd_data <= '0;
                    bus_err     <= 1'b0;
                    state_q     <= o_bus_req ? WAIT_DROP : IDLE;
                end
                WAIT_DROP: begin
                    if (!o_bus_req) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctrl_o = regs_q[CTRL_IDX];
    assign irq_o  = |(regs_q[STATUS_IDX] & regs_q[CTRL_IDX]);

endmodule

// File: tb/tb_csr_reg_bank.sv
// Randomized bench for csr_reg_bank: address-level reference model feeds a response queue drained by a monitor.
module tb_csr_reg_bank;
    localparam int          AW  = 3;
    localparam int          DW  = 32;
    localparam int          NR  = 5;
    localparam logic [31:0] IDV = 32'hC5A0_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          is_wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    biten = '0;
    logic [DW-1:0] hw_set = '0;
    logic          bus_ready;
    logic [DW-1:0] bus_rd_data;
    logic          bus_err;
    logic [DW-1:0] ctrl_o;
    logic          irq_o;

    csr_reg_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .ID_VALUE(IDV)) dut (
        .clk(clk), .rst(rst),
        .o_bus_req(req), .o_bus_req_is_wr(is_wr), .o_bus_addr(addr),
        .o_bus_wr_data(wdata), .o_bus_wr_biten(biten),
        .bus_ready(bus_ready), .bus_rd_data(bus_rd_data), .bus_err(bus_err),
        .hw_set(hw_set), .ctrl_o(ctrl_o), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycle;
    } exp_t;

    exp_t        expq[$];
    logic [31:0] m_reg [8];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Reference model: applies the effect of the upcoming clock edge to the address-indexed register image.
    task automatic model_apply(bit commit_now);
        logic [31:0] clr;
        int          a;
        exp_t        e;
        clr = '0;
        if (rst) begin
            foreach (m_reg[i]) m_reg[i] = '0;
            return;
        end
        if (commit_now) begin
            a       = int'(addr);
            e.cycle = cyc + 1;
            e.data  = '0;
            e.err   = 1'b0;
            if (a >= NR || (is_wr && a == 2)) begin
                e.err = 1'b1;
            end else if (!is_wr) begin
                e.data = (a == 2) ? IDV : m_reg[a];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (biten[b]) begin
                        if (a == 1) clr[8*b +: 8] = wdata[8*b +: 8];
                        else        m_reg[a][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end
            expq.push_back(e);
        end
        m_reg[1] = (m_reg[1] & ~clr) | hw_set;
    endtask

    task automatic step(bit commit_now);
        model_apply(commit_now);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic op(bit w, int a, logic [31:0] d, logic [3:0] be, int hold, logic [31:0] hs);
        req    = 1'b1;
        is_wr  = w;
        addr   = AW'(a);
        wdata  = d;
        biten  = be;
        hw_set = hs;
        step(1'b1);
        hw_set = '0;
        repeat (hold) step(1'b0);
        req = 1'b0;
        step(1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (bus_ready) begin
                check("ready_expected", 32'(expq.size() > 0), 32'd1);
                if (expq.size() > 0) begin
                    e = expq.pop_front();
                    check("rd_data", bus_rd_data, e.data);
                    check("err", 32'(bus_err), 32'(e.err));
                    check("latency", 32'(cyc), 32'(e.cycle));
                end
            end else begin
                check("idle_rd_data", bus_rd_data, 32'h0);
                check("idle_err", 32'(bus_err), 32'h0);
            end
            check("ctrl_o", ctrl_o, m_reg[0]);
            check("irq_o", 32'(irq_o), 32'(|(m_reg[0] & m_reg[1])));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        #1;
        step(1'b0);
        step(1'b0);
        mon_en = 1'b1;
        check("reset_ready", 32'(bus_ready), 32'h0);
        check("reset_rd_data", bus_rd_data, 32'h0);
        check("reset_ctrl", ctrl_o, 32'h0);
        check("reset_irq", 32'(irq_o), 32'h0);
        rst = 1'b0;

        op(1'b0, 2, 32'h0, 4'h0, 0, 32'h0);
        op(1'b1, 0, 32'hAABBCCDD, 4'b0101, 0, 32'h0);
        check("t2_ctrl", ctrl_o, 32'h00BB00DD);
        op(1'b0, 0, 32'h0, 4'h0, 0, 32'h0);

        hw_set = 32'h9;
        step(1'b0);
        hw_set = '0;
        op(1'b0, 1, 32'h0, 4'h0, 0, 32'h0);
        op(1'b1, 1, 32'h9, 4'hF, 2, 32'h8);
        op(1'b0, 1, 32'h0, 4'h0, 1, 32'h0);

        op(1'b1, 0, 32'h8, 4'hF, 0, 32'h0);
        check("t4_irq_set", 32'(irq_o), 32'h1);
        op(1'b1, 1, 32'h8, 4'hF, 0, 32'h0);
        check("t4_irq_clr", 32'(irq_o), 32'h0);

        op(1'b1, 2, 32'h0, 4'hF, 0, 32'h0);
        op(1'b0, 2, 32'h0, 4'h0, 0, 32'h0);
        op(1'b0, 7, 32'h0, 4'h0, 0, 32'h0);
        op(1'b1, 3, 32'hFFFF_FFFF, 4'h0, 0, 32'h0);
        op(1'b0, 3, 32'h0, 4'h0, 0, 32'h0);

        op(1'b1, 4, 32'h1234_5678, 4'hF, 0, 32'h0);
        req = 1'b1; is_wr = 1'b1; addr = AW'(3); wdata = 32'hDEAD_BEEF; biten = 4'hF;
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        req = 1'b0;
        step(1'b0);
        op(1'b0, 3, 32'h0, 4'h0, 0, 32'h0);
        op(1'b0, 4, 32'h0, 4'h0, 0, 32'h0);

        for (int n = 0; n < 150; n++) begin
            op(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
               4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
               ($urandom_range(0, 3) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'h0);
            if ($urandom_range(0, 2) == 0) begin
                hw_set = ($urandom_range(0, 1) == 0) ? (32'd1 << $urandom_range(0, 7)) : 32'h0;
                step(1'b0);
                hw_set = '0;
            end
        end

        repeat (4) step(1'b0);
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
